// File: rtl/sc_rndcapture.sv
// Captures a free-running random value on a debounced button press, reduces it
// into 0..L by repeated subtraction of L+1, and queues results in a FWFT FIFO.
module sc_rndcapture #(
   parameter int RndCAPTURE_DATAWIDTH = 8,
   parameter int RndCAPTURE_DEPTH     = 4
) (
   input  logic                            SC_RndCAPTURE_CLOCK_50,
   input  logic                            SC_RndCAPTURE_RESET_InLow,
   input  logic [RndCAPTURE_DATAWIDTH-1:0] SC_RndCAPTURE_data_InBUS,
   input  logic                            SC_RndCAPTURE_request_InLow,
   input  logic [RndCAPTURE_DATAWIDTH-1:0] SC_RndCAPTURE_limit_InBUS,
   input  logic                            SC_RndCAPTURE_ready_In,
   output logic [RndCAPTURE_DATAWIDTH-1:0] SC_RndCAPTURE_data_OutBUS,
   output logic                            SC_RndCAPTURE_valid_Out,
   output logic                            SC_RndCAPTURE_full_Out,
   output logic [2:0]                      SC_RndCAPTURE_count_OutBUS,
   output logic                            SC_RndCAPTURE_overflow_Out
);

   localparam int W  = RndCAPTURE_DATAWIDTH;
   localparam int D  = RndCAPTURE_DEPTH;
   localparam int PW = (D > 1) ? $clog2(D) : 1;

   typedef enum logic [1:0] {IDLE, REDUCE, PUSH} state_t;

   logic         clk;
   logic         rst_n;
   assign clk   = SC_RndCAPTURE_CLOCK_50;
   assign rst_n = SC_RndCAPTURE_RESET_InLow;

   logic         sync1_q, sync2_q, prev_q;
   state_t       state_q, state_d;
   logic [W-1:0] r_q, r_d;
   logic [W:0]   m_q, m_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]   count_q, count_d;
   logic         overflow_q, overflow_d;
   logic [W-1:0] fifo_mem_q [D];

   logic strobe, push, pop, full, valid;

   // A press is the falling edge of the synchronised button level.
   assign strobe = prev_q & ~sync2_q;
   assign valid  = (count_q != 3'd0);
   assign full   = (count_q == 3'(D));
   assign pop    = valid & SC_RndCAPTURE_ready_In;

   // NOTE: combinational blocks use blocking '=' and give every output a default
   // first, so no latch is inferred; clocked blocks use non-blocking '<=' only.
   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      m_d        = m_q;
      overflow_d = overflow_q;
      push       = 1'b0;
      case (state_q)
         IDLE: begin
            if (strobe) begin
               r_d     = SC_RndCAPTURE_data_InBUS;
               m_d     = {1'b0, SC_RndCAPTURE_limit_InBUS} + (W+1)'(1);
               state_d = REDUCE;
            end
         end
         REDUCE: begin
            // M can only be 2^W when L is all-ones, and then R < M always holds.
            if ({1'b0, r_q} >= m_q) r_d = r_q - m_q[W-1:0];
            else                     state_d = PUSH;
         end
         PUSH: begin
            if (!full || pop) push = 1'b1;
            else              overflow_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = (wr_ptr_q == PW'(D-1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PW'(D-1)) ? '0 : rd_ptr_q + PW'(1);
      count_d = count_q + 3'(push) - 3'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
         state_q    <= IDLE;
         r_q        <= '0;
         m_q        <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         sync1_q    <= SC_RndCAPTURE_request_InLow;
         sync2_q    <= sync1_q;
         prev_q     <= sync2_q;
         state_q    <= state_d;
         r_q        <= r_d;
         m_q        <= m_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: FIFO storage has no reset; entries are only observed once count
   // marks them valid, so clearing them would buy nothing.
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= r_q;
   end

   assign SC_RndCAPTURE_data_OutBUS  = valid ? fifo_mem_q[rd_ptr_q] : '0;
   assign SC_RndCAPTURE_valid_Out    = valid;
   assign SC_RndCAPTURE_full_Out     = full;
   assign SC_RndCAPTURE_count_OutBUS = count_q;
   assign SC_RndCAPTURE_overflow_Out = overflow_q;

endmodule

// File: doc/sc_rndcapture.md
SC_RNDCAPTURE -- requirements
Module: SC_RndCAPTURE

Interface
REQ-001 SHALL have parameter RndCAPTURE_DATAWIDTH, default 8, giving the width of the random value, limit and output data.
REQ-002 SHALL have parameter RndCAPTURE_DEPTH, default 4, giving the output FIFO depth in entries.
REQ-003 SHALL have port SC_RndCAPTURE_CLOCK_50  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port SC_RndCAPTURE_RESET_InLow  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SC_RndCAPTURE_data_InBUS  input  W  free-running random value from the upstream shifter stage.
REQ-006 SHALL have port SC_RndCAPTURE_request_InLow  input  1  asynchronous push-button request, active-low.
REQ-007 SHALL have port SC_RndCAPTURE_limit_InBUS  input  W  inclusive upper bound L of the reduced value.
REQ-008 SHALL have port SC_RndCAPTURE_ready_In  input  1  downstream consumer ready.
REQ-009 SHALL have port SC_RndCAPTURE_data_OutBUS  output  W  FIFO head value; 0 when FIFO empty.
REQ-010 SHALL have port SC_RndCAPTURE_valid_Out  output  1  high when FIFO count != 0.
REQ-011 SHALL have port SC_RndCAPTURE_full_Out  output  1  high when count == DEPTH.
REQ-012 SHALL have port SC_RndCAPTURE_count_OutBUS  output  3  FIFO occupancy, 0..DEPTH.
REQ-013 SHALL have port SC_RndCAPTURE_overflow_Out  output  1  sticky flag: a reduced value was dropped.

Function
REQ-014 SHALL synchronize request_InLow through two flip-flops (sync1, sync2) plus a history flop prev, all initialised to 1.
REQ-015 SHALL generate a one-cycle strobe when prev=1 and sync2=0 (button press); holding the button SHALL produce no further strobes.
REQ-016 SHALL implement FSM states IDLE, REDUCE, PUSH.
REQ-017 IDLE: on strobe, SHALL load R <= data_InBUS and M <= L+1 (computed in W+1 bits, so L=255 gives M=256) and go to REDUCE.
REQ-018 REDUCE: each cycle, if R >= M then R <= R-M and stay; else go to PUSH.
REQ-019 L=0 SHALL give result 0, reached by repeated subtraction (k = data iterations).
REQ-020 PUSH: SHALL write R into the FIFO tail if not full (or if a pop occurs the same cycle), else discard R and set overflow_Out; then return to IDLE.
REQ-021 Strobes arriving in REDUCE or PUSH SHALL be ignored.
REQ-022 With E0 the edge that samples request low into sync1 and k = floor(data/M), valid_Out SHALL rise after edge E0+k+4 when the FIFO was empty.
REQ-023 FIFO SHALL be first-word-fall-through with data_OutBUS = oldest entry.
REQ-024 A pop SHALL occur on every edge where valid_Out=1 and ready_In=1.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-026 ready_In while empty SHALL have no effect.
REQ-027 overflow_Out SHALL remain set until reset.

Reset
REQ-028 RESET_InLow=0 SHALL immediately force the following, independent of the clock: FSM=IDLE, R=0, pointers=0, count=0, data_OutBUS=0, valid_Out=0, full_Out=0, overflow_Out=0, sync1=sync2=prev=1.
REQ-029 Reset asserted mid-REDUCE or mid-PUSH SHALL abort the operation; no write SHALL follow reset release.
REQ-030 Release of reset with request_InLow already low SHALL produce exactly one strobe (a press), 2-3 edges later.

Verification
REQ-031 Reset: assert RESET_InLow=0 with random inputs -> all outputs 0; release with request high for 20 cycles -> count stays 0.
REQ-032 data=199, L=9, request low 30 cycles -> valid_Out rises after edge E0+23, data_OutBUS=9, count=1, one entry only.
REQ-033 L=255, data=0xAB -> data_OutBUS=0xAB after edge E0+4; L=0, data=0x05 -> data_OutBUS=0 after edge E0+9.
REQ-034 ready_In=0, five presses with data 1,2,3,4,5 and L=255 -> count=4, full=1, overflow=1; then ready_In=1 -> outputs 1,2,3,4 in order, count returns to 0, overflow stays 1.
REQ-035 FIFO full, ready_In=1 asserted on the PUSH cycle -> new value accepted, count stays 4, overflow stays 0.
REQ-036 Reset pulse during REDUCE (data=250, L=1) -> after release count=0 and valid_Out=0 for 300 cycles.
